// File: rtl/uart_baud_ctrl.sv
// Baud-rate tick scheduler: one runtime divisor drives the oversample, TX bit and RX mid-bit strobes.
// Divisor updates are handshaked and only take effect at an os_tick boundary.
module uart_baud_ctrl #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_DIV = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             rx_sync,
  output logic             os_tick,
  output logic             tx_tick,
  output logic             rx_sample_tick,
  output logic [DIV_W-1:0] div_active
);

  localparam int unsigned      OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  TX_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  RX_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt, div_reg, pend_div, cfg_clamped;
  logic [OS_W-1:0]  tx_os, rx_os;
  logic             pend_valid, xfer, wrap;

  assign pend_valid  = (state_q == PEND);
  assign cfg_ready   = !pend_valid;
  assign xfer        = cfg_valid && cfg_ready;
  assign cfg_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
  assign wrap        = enable && (cnt == div_reg - DIV_W'(1));
  assign div_active  = div_reg;

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        PEND:    state_d = wrap ? RUN : PEND;
        default: state_d = xfer ? PEND : RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt            <= '0;
      tx_os          <= '0;
      rx_os          <= '0;
      os_tick        <= 1'b0;
      tx_tick        <= 1'b0;
      rx_sample_tick <= 1'b0;
      div_reg        <= DIV_RST;
      pend_div       <= '0;
    end else begin
      state_q        <= state_d;
      os_tick        <= wrap;
      tx_tick        <= wrap && (tx_os == TX_LAST);
      // a coincident rx_sync restarts the phase, so that tick cannot sample
      rx_sample_tick <= wrap && !rx_sync && (rx_os == RX_MID);
      if (!enable) begin
        cnt   <= '0;
        tx_os <= '0;
        rx_os <= '0;
        if (pend_valid)
          div_reg <= pend_div;
        else if (xfer)
          div_reg <= cfg_clamped;
      end else begin
        cnt <= wrap ? '0 : cnt + DIV_W'(1);
        if (wrap)
          tx_os <= tx_os + OS_W'(1);
        if (rx_sync)
          rx_os <= '0;
        else if (wrap)
          rx_os <= rx_os + OS_W'(1);
        // a value captured on a wrap edge waits for the next wrap
        if (wrap && pend_valid)
          div_reg <= pend_div;
        if (xfer)
          pend_div <= cfg_clamped;
      end
    end
  end

endmodule
